word_concatenator: RTL and testbench
====================================

// Module: word_concatenator
// PURPOSE
//   Packs a stream of narrow input words into one wide output word.
//   Collects NUM_WORDS_TO_CONCAT valid input words, then presents them
//   concatenated for one cycle. Sits between byte/word-wide sources
//   (UART, SPI, FIFO readers) and wider consumers; no backpressure.
// PARAMETERS
//   INPUT_WIDTH          8         width of each input word, >= 1
//   NUM_WORDS_TO_CONCAT  4         words per output, >= 2
//   ENDIAN               "little"  "little": first word -> LSBs; "big": first word -> MSBs
// PORTS
//   clk_i                     in   1                      single clock, rising edge
//   reset_i                   in   1                      asynchronous, active-high reset
//   data_i                    in   INPUT_WIDTH            input word
//   data_valid_i              in   1                      data_i is valid this cycle
//   accumulated_data_o        out  INPUT_WIDTH*NUM_WORDS  concatenated word
//   accumulated_data_valid_o  out  1                      one-cycle pulse, accumulated_data_o new
// BEHAVIOUR
//   - One clock (clk_i). reset_i is asynchronous, active-high.
//   - While reset_i is high: word count = 0, shift/accumulate register = 0,
//     accumulated_data_o = 0, accumulated_data_valid_o = 0.
//   - Input word accepted on every rising edge with data_valid_i = 1;
//     data_valid_i = 0 cycles are ignored and do not disturb partial state.
//   - Word index k = 0..N-1 in arrival order (N = NUM_WORDS_TO_CONCAT).
//     little: word k -> bits [k*W +: W]; big: word k -> bits [(N-1-k)*W +: W].
//   - Count runs 0..N-1. On the edge accepting word k = N-1:
//     accumulated_data_o <= complete word (including this word),
//     accumulated_data_valid_o <= 1, count <= 0.
//     Valid is high exactly the one cycle after that edge (latency 1 from
//     final input word); it is registered, not combinational.
//   - accumulated_data_o holds its last complete value between pulses;
//     partial accumulation never appears on the output.
//   - Back-to-back: valid input every cycle gives one pulse every N cycles,
//     with no lost words.
//   - Reset mid-accumulation discards partial words; the next word after
//     release is word 0.
//   - ENDIAN values other than "little"/"big" are an elaboration error
//     (generate-time $error).
// STRUCTURE
//   - No shared package; output width is a localparam OUT_W = INPUT_WIDTH*N.
//   - Count width is a localparam $clog2(N).
//   - Single module: a count register, an accumulation register and an
//     output register with its valid flop. No sub-modules.
// TESTING
//   - little, W=8, N=4: 01,02,03,04 consecutive
//     -> single pulse, out = 32'h04030201.
//   - big, same stimulus -> out = 32'h01020304.
//   - little: 0A, gap, 0B, gap x3, 0C, 0D -> out = 32'h0D0C0B0A;
//     no pulse before 0D is accepted.
//   - Reset after AA,BB; release, then 01..04 -> out = 32'h04030201;
//     valid = 0 and out = 0 during reset.
//   - 8 consecutive words 01..08 -> pulses 4 cycles apart: 32'h04030201,
//     then 32'h08070605; out holds 32'h08070605 afterwards.
//   - 10000 cycles, random valid (~75%), incrementing data
//     -> scoreboard matches every packed word; pulse count = accepted/4.

Source files
------------

// File: rtl/word_concatenator.sv
// word_concatenator: packs N narrow input words into one wide output word.
// Emits a one-cycle registered valid pulse with each completed word.
module word_concatenator #(
   parameter int    INPUT_WIDTH         = 8,
   parameter int    NUM_WORDS_TO_CONCAT = 4,
   parameter string ENDIAN              = "little"
) (
   input  logic                                       clk_i,
   input  logic                                       reset_i,
   input  logic [INPUT_WIDTH-1:0]                     data_i,
   input  logic                                       data_valid_i,
   output logic [INPUT_WIDTH*NUM_WORDS_TO_CONCAT-1:0] accumulated_data_o,
   output logic                                       accumulated_data_valid_o
);

   localparam int W     = INPUT_WIDTH;
   localparam int N     = NUM_WORDS_TO_CONCAT;
   localparam int OUT_W = W * N;
   localparam int CNT_W = $clog2(N);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   localparam bit IS_BIG    = (ENDIAN == "big");
   localparam bit IS_LITTLE = (ENDIAN == "little");

   generate
      if (!(IS_BIG || IS_LITTLE)) begin : g_bad_endian
         $error("word_concatenator: ENDIAN must be \"little\" or \"big\"");
      end
   endgenerate

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             vld_q, vld_d;
   logic [OUT_W-1:0] shifted;

   // Shift the new word in so that after N words word 0 sits at the
   // end selected by ENDIAN; no per-index muxing is needed.
   always_comb begin
      shifted = acc_q;
      if (IS_BIG) begin
         shifted = {acc_q[OUT_W-W-1:0], data_i};
      end else begin
         shifted = {data_i, acc_q[OUT_W-1:W]};
      end
   end

   // Next state: accept on valid, publish on the last word of a group.
   always_comb begin
      cnt_d = cnt_q;
      acc_d = acc_q;
      out_d = out_q;
      vld_d = 1'b0;
      if (data_valid_i) begin
         acc_d = shifted;
         if (cnt_q == LAST) begin
            cnt_d = '0;
            out_d = shifted;
            vld_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers; reset drops any partial group.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
         acc_q <= '0;
         out_q <= '0;
         vld_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         out_q <= out_d;
         vld_q <= vld_d;
      end
   end

   assign accumulated_data_o       = out_q;
   assign accumulated_data_valid_o = vld_q;

endmodule

// File: tb/tb_word_concatenator.sv
// tb_word_concatenator: scoreboard bench driving a little- and a
// big-endian instance with the same word stream.
module tb_word_concatenator;

   logic        clk;
   logic        rst;
   logic [7:0]  din;
   logic        dv;
   logic [31:0] ol, ob;
   logic        vl, vb;

   logic [31:0] q_l[$];
   logic [31:0] q_b[$];
   logic [31:0] last_l, last_b;

   int nvec, miss;
   int pulses_l, pulses_b, pushes;
   int cyc, last_cyc, prev_cyc;

   word_concatenator #(
      .INPUT_WIDTH(8),
      .NUM_WORDS_TO_CONCAT(4),
      .ENDIAN("little")
   ) u_little (
      .clk_i(clk),
      .reset_i(rst),
      .data_i(din),
      .data_valid_i(dv),
      .accumulated_data_o(ol),
      .accumulated_data_valid_o(vl)
   );

   word_concatenator #(
      .INPUT_WIDTH(8),
      .NUM_WORDS_TO_CONCAT(4),
      .ENDIAN("big")
   ) u_big (
      .clk_i(clk),
      .reset_i(rst),
      .data_i(din),
      .data_valid_i(dv),
      .accumulated_data_o(ob),
      .accumulated_data_valid_o(vb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Monitor: pop and compare on each pulse, check hold otherwise.
   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst) begin
         nvec++;
         if (vl) begin
            pulses_l++;
            if (q_l.size() == 0) begin
               miss++;
               $display("FAIL pulse_little unexpected: got %h, required no pulse", ol);
            end else begin
               e = q_l.pop_front();
               if (ol !== e) begin
                  miss++;
                  $display("FAIL data_little: got %h, required %h", ol, e);
               end
               last_l   = e;
               prev_cyc = last_cyc;
               last_cyc = cyc;
            end
         end else if (ol !== last_l) begin
            miss++;
            $display("FAIL hold_little: got %h, required %h", ol, last_l);
         end
         nvec++;
         if (vb) begin
            pulses_b++;
            if (q_b.size() == 0) begin
               miss++;
               $display("FAIL pulse_big unexpected: got %h, required no pulse", ob);
            end else begin
               e = q_b.pop_front();
               if (ob !== e) begin
                  miss++;
                  $display("FAIL data_big: got %h, required %h", ob, e);
               end
               last_b = e;
            end
         end else if (ob !== last_b) begin
            miss++;
            $display("FAIL hold_big: got %h, required %h", ob, last_b);
         end
      end
   end

   task automatic drive(input logic v, input logic [7:0] d);
      @(negedge clk);
      dv  = v;
      din = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
   endtask

   task automatic expect_pkt(input logic [31:0] el, input logic [31:0] eb);
      q_l.push_back(el);
      q_b.push_back(eb);
      pushes++;
   endtask

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] req);
      nvec++;
      if (got !== req) begin
         miss++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   initial begin
      logic [7:0] buf_w[4];
      logic [7:0] d;
      int         n;

      nvec = 0; miss = 0;
      pulses_l = 0; pulses_b = 0; pushes = 0;
      cyc = 0; last_cyc = 0; prev_cyc = 0;
      last_l = '0; last_b = '0;
      rst = 1'b1; dv = 1'b0; din = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_little", ol, 32'h0);
      chk("reset_out_big", ob, 32'h0);
      chk("reset_vld_little", {31'b0, vl}, 32'h0);
      chk("reset_vld_big", {31'b0, vb}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Four consecutive words
      drive(1'b1, 8'h01);
      drive(1'b1, 8'h02);
      drive(1'b1, 8'h03);
      expect_pkt(32'h04030201, 32'h01020304);
      drive(1'b1, 8'h04);
      idle(3);

      // Gaps must not disturb partial state
      drive(1'b1, 8'h0A);
      idle(1);
      drive(1'b1, 8'h0B);
      idle(3);
      drive(1'b1, 8'h0C);
      expect_pkt(32'h0D0C0B0A, 32'h0A0B0C0D);
      drive(1'b1, 8'h0D);
      idle(3);

      // Reset mid-group discards partial words
      drive(1'b1, 8'hAA);
      drive(1'b1, 8'hBB);
      @(negedge clk);
      dv = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("midreset_out_little", ol, 32'h0);
      chk("midreset_out_big", ob, 32'h0);
      chk("midreset_vld_little", {31'b0, vl}, 32'h0);
      chk("midreset_vld_big", {31'b0, vb}, 32'h0);
      last_l = '0;
      last_b = '0;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 8'h01);
      drive(1'b1, 8'h02);
      drive(1'b1, 8'h03);
      expect_pkt(32'h04030201, 32'h01020304);
      drive(1'b1, 8'h04);
      idle(3);

      // Back-to-back groups
      for (int i = 1; i <= 8; i++) begin
         if (i == 4) expect_pkt(32'h04030201, 32'h01020304);
         if (i == 8) expect_pkt(32'h08070605, 32'h05060708);
         drive(1'b1, 8'(i));
      end
      idle(4);
      chk("b2b_spacing", 32'(last_cyc - prev_cyc), 32'd4);
      chk("b2b_hold_little", ol, 32'h08070605);
      chk("b2b_hold_big", ob, 32'h05060708);

      // Random valid, incrementing data
      d = 8'h00;
      n = 0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            buf_w[n] = d;
            n++;
            if (n == 4) begin
               expect_pkt({buf_w[3], buf_w[2], buf_w[1], buf_w[0]},
                          {buf_w[0], buf_w[1], buf_w[2], buf_w[3]});
               n = 0;
            end
            drive(1'b1, d);
            d++;
         end else begin
            drive(1'b0, 8'h00);
         end
      end
      idle(4);

      chk("pulses_little", 32'(pulses_l), 32'(pushes));
      chk("pulses_big", 32'(pulses_b), 32'(pushes));
      chk("queue_little_empty", 32'(q_l.size()), 32'd0);
      chk("queue_big_empty", 32'(q_b.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, miss);
      $finish;
   end

endmodule
